// File: rtl/operand_fetch.sv
// Operand fetch sequencer: reads memory A in pairs into the adder operand registers and writes each sum to memory B.
// Optional build macro OPFETCH_SAT_EN saturates the written sum on signed overflow instead of wrapping.
module operand_fetch #(
    parameter int DATA_W    = 8,
    parameter int ADDR_A_W  = 4,
    parameter int ADDR_B_W  = 3,
    parameter int NUM_PAIRS = 8
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                Start,
    output logic                Busy,
    output logic                Done,
    output logic                RdA,
    output logic [ADDR_A_W-1:0] AddrA,
    input  logic [DATA_W-1:0]   DataA,
    output logic [DATA_W-1:0]   DOut1,
    output logic [DATA_W-1:0]   DOut2,
    input  logic [DATA_W-1:0]   ADDOut,
    output logic                WeB,
    output logic [ADDR_B_W-1:0] AddrB,
    output logic [DATA_W-1:0]   DataB
);

    typedef enum logic [2:0] {IDLE, FETCH1, LOAD1, LOAD2, WRITE, DONE} state_t;

    localparam logic [ADDR_B_W-1:0] K_LAST = ADDR_B_W'(NUM_PAIRS - 1);

    state_t              state;
    logic [ADDR_B_W-1:0] k;
    logic [DATA_W-1:0]   sum;

    // Memory A word address of the even (odd=0) or odd (odd=1) operand of a pair.
    function automatic logic [ADDR_A_W-1:0] word_addr(input logic [ADDR_B_W-1:0] pair,
                                                      input logic odd);
        return ADDR_A_W'({pair, odd});
    endfunction

`ifdef OPFETCH_SAT_EN
    localparam logic signed [DATA_W-1:0] SAT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic signed [DATA_W-1:0] SAT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

    // Overflow only when both operands share a sign that the wrapped sum lost.
    function automatic logic signed [DATA_W-1:0] sat_sum(input logic signed [DATA_W-1:0] a,
                                                         input logic signed [DATA_W-1:0] b,
                                                         input logic signed [DATA_W-1:0] s);
        if ((a[DATA_W-1] == b[DATA_W-1]) && (s[DATA_W-1] != a[DATA_W-1]))
            return a[DATA_W-1] ? SAT_MIN : SAT_MAX;
        return s;
    endfunction

    assign sum = sat_sum(DOut1, DOut2, ADDOut);
`else
    assign sum = ADDOut;
`endif

    assign AddrB = k;
    assign DataB = WeB ? sum : '0;

    // Strobes and addresses are set one state ahead so they leave the flops glitch-free.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            k     <= '0;
            Busy  <= 1'b0;
            Done  <= 1'b0;
            RdA   <= 1'b0;
            AddrA <= '0;
            WeB   <= 1'b0;
            DOut1 <= '0;
            DOut2 <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (Start) begin
                        k     <= '0;
                        Busy  <= 1'b1;
                        RdA   <= 1'b1;
                        AddrA <= '0;
                        state <= FETCH1;
                    end
                end
                FETCH1: begin
                    RdA   <= 1'b1;
                    AddrA <= word_addr(k, 1'b1);
                    state <= LOAD1;
                end
                LOAD1: begin
                    DOut1 <= DataA;
                    RdA   <= 1'b0;
                    state <= LOAD2;
                end
                LOAD2: begin
                    DOut2 <= DataA;
                    WeB   <= 1'b1;
                    state <= WRITE;
                end
                WRITE: begin
                    WeB <= 1'b0;
                    if (k == K_LAST) begin
                        Done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        k     <= k + ADDR_B_W'(1);
                        RdA   <= 1'b1;
                        AddrA <= word_addr(k + ADDR_B_W'(1), 1'b0);
                        state <= FETCH1;
                    end
                end
                DONE: begin
                    Done  <= 1'b0;
                    Busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    Busy  <= 1'b0;
                    Done  <= 1'b0;
                    RdA   <= 1'b0;
                    WeB   <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_operand_fetch.sv
// Scoreboard bench for operand_fetch: memory A/B and adder models, reference sums queued per run, monitor checks writes and Done timing.
module tb_operand_fetch;
    localparam int DW  = 8;
    localparam int AAW = 4;
    localparam int ABW = 3;
    localparam int NP  = 5;

    logic           clock = 1'b0;
    logic           reset;
    logic           Start;
    logic           Busy, Done, RdA, WeB;
    logic [AAW-1:0] AddrA;
    logic [ABW-1:0] AddrB;
    logic [DW-1:0]  DataA, DOut1, DOut2, ADDOut, DataB;

    always #5 clock = ~clock;

    operand_fetch #(.DATA_W(DW), .ADDR_A_W(AAW), .ADDR_B_W(ABW), .NUM_PAIRS(NP)) dut (
        .clock(clock), .reset(reset), .Start(Start), .Busy(Busy), .Done(Done),
        .RdA(RdA), .AddrA(AddrA), .DataA(DataA), .DOut1(DOut1), .DOut2(DOut2),
        .ADDOut(ADDOut), .WeB(WeB), .AddrB(AddrB), .DataB(DataB)
    );

    logic [DW-1:0] mema [16];
    logic [DW-1:0] memb [8];

    always @(posedge clock) if (RdA) DataA <= mema[AddrA];
    always @(posedge clock) if (WeB) memb[AddrB] <= DataB;
    assign ADDOut = DOut1 + DOut2;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct { int addr; int val; } wr_t;
    wr_t expq[$];
    int  doneq[$];
    int  rd_addr[2];
    int  rd_cyc[2];
    wr_t w;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int sx(input int v);
        return (v >= 128) ? v - 256 : v;
    endfunction

    function automatic int ref_sum(input int a, input int b);
        int s;
        s = sx(a) + sx(b);
`ifdef OPFETCH_SAT_EN
        if (s > 127)  s = 127;
        if (s < -128) s = -128;
`endif
        return s & 255;
    endfunction

    task automatic push_run(input int s);
        for (int p = 0; p < NP; p++)
            expq.push_back('{p, ref_sum(mema[2*p], mema[2*p+1])});
        doneq.push_back(s + 4*NP + 1);
    endtask

    // Monitor: every write and every Done pulse is matched against the scoreboard.
    always @(negedge clock) begin
        if (RdA) begin
            rd_addr[0] = rd_addr[1];
            rd_cyc[0]  = rd_cyc[1];
            rd_addr[1] = AddrA;
            rd_cyc[1]  = cyc;
        end
        if (WeB) begin
            check("rd_we_exclusive", RdA, 0);
            if (expq.size() == 0) begin
                check("unexpected_write", 1, 0);
            end else begin
                w = expq.pop_front();
                check("addrb", AddrB, w.addr);
                check("datab", DataB, w.val);
            end
            check("rd_even_addr", rd_addr[0], 2*AddrB);
            check("rd_even_cyc", rd_cyc[0], cyc - 3);
            check("rd_odd_addr", rd_addr[1], 2*AddrB + 1);
            check("rd_odd_cyc", rd_cyc[1], cyc - 2);
        end
        if (Done) begin
            if (doneq.size() == 0) check("unexpected_done", 1, 0);
            else check("done_cycle", cyc, doneq.pop_front());
        end
    end

    task automatic fill_random();
        for (int i = 0; i < 16; i++) mema[i] = DW'($urandom_range(0, 255));
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((expq.size() != 0 || doneq.size() != 0) && n < 300) begin
            @(negedge clock);
            n++;
        end
        check("drain_timeout", expq.size() + doneq.size(), 0);
        n = 0;
        while (Busy && n < 20) begin
            @(negedge clock);
            n++;
        end
        check("idle_timeout", Busy, 0);
    endtask

    // Called at a negedge with the DUT idle; returns the cycle in which Start is sampled.
    task automatic pulse_start(output int s);
        s = cyc;
        push_run(s);
        Start = 1'b1;
        @(negedge clock);
        Start = 1'b0;
    endtask

    logic [DW-1:0] plan [10] = '{8'h00, 8'h7F, 8'h22, 8'h49, 8'hE0, 8'hC7, 8'h7F, 8'h01, 8'h80, 8'hFF};
`ifdef OPFETCH_SAT_EN
    logic [DW-1:0] plan_b [5] = '{8'h7F, 8'h6B, 8'hA7, 8'h7F, 8'h80};
`else
    logic [DW-1:0] plan_b [5] = '{8'h7F, 8'h6B, 8'hA7, 8'h80, 8'h7F};
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int s;
        reset = 1'b1;
        Start = 1'b0;
        fill_random();
        repeat (2) @(negedge clock);
        check("rst_ctrl", {Busy, Done, RdA, WeB, AddrA, AddrB}, 0);
        check("rst_data", {DOut1, DOut2, DataB}, 0);
        reset = 1'b0;
        repeat (2) @(negedge clock);
        check("idle_after_rst", {Busy, RdA, WeB}, 0);

        // Directed vector with wrap and overflow cases
        for (int i = 0; i < 10; i++) mema[i] = plan[i];
        pulse_start(s);
        wait_idle();
        for (int i = 0; i < NP; i++) check($sformatf("plan_memb%0d", i), memb[i], plan_b[i]);

        // Start while busy is ignored
        fill_random();
        pulse_start(s);
        while (cyc < s + 10) @(negedge clock);
        check("busy_mid_run", Busy, 1);
        Start = 1'b1;
        @(negedge clock);
        Start = 1'b0;
        wait_idle();

        // Asynchronous reset during LOAD1 of pair 3
        fill_random();
        pulse_start(s);
        while (cyc < s + 14) @(negedge clock);
        check("load1_p3_addr", {RdA, AddrA}, {1'b1, 4'd7});
        #1 reset = 1'b1;
        #1;
        check("async_rst_ctrl", {Busy, Done, RdA, WeB, AddrA, AddrB}, 0);
        check("async_rst_data", {DOut1, DOut2, DataB}, 0);
        expq.delete();
        doneq.delete();
        repeat (2) @(negedge clock);
        reset = 1'b0;
        repeat (3) @(negedge clock);
        check("idle_after_abort", Busy, 0);
        fill_random();
        pulse_start(s);
        check("restart_addr0", {RdA, AddrA}, {1'b1, 4'd0});
        wait_idle();

        // Start held high: back-to-back runs with one IDLE cycle between
        fill_random();
        s = cyc;
        push_run(s);
        push_run(s + 4*NP + 2);
        Start = 1'b1;
        while (cyc < s + 4*NP + 2) @(negedge clock);
        check("gap_idle", Busy, 0);
        @(negedge clock);
        Start = 1'b0;
        check("gap_fetch", {Busy, RdA, AddrA}, {1'b1, 1'b1, 4'd0});
        wait_idle();

        // All operands -1
        for (int i = 0; i < 16; i++) mema[i] = 8'hFF;
        pulse_start(s);
        wait_idle();
        for (int i = 0; i < NP; i++) check($sformatf("ff_memb%0d", i), memb[i], 8'hFE);

        // Randomized runs
        for (int r = 0; r < 8; r++) begin
            fill_random();
            repeat ($urandom_range(0, 3)) @(negedge clock);
            pulse_start(s);
            wait_idle();
        end

        repeat (3) @(negedge clock);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
